// File: rtl/mem_pkg.sv
// Shared constants for the MOV/MOC memory handshake: access sizes, RW encoding
// and the responder FSM state type.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Number of bytes touched by an access; reserved size touches none.
  function automatic int unsigned size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 1;
      SIZE_HALF: return 2;
      SIZE_WORD: return 4;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Big-endian byte-lane steering: lane i is byte address A+i (mod 2^ADDR_W);
// forms per-lane addresses, write bytes/enables and the assembled read word.
module mem_lane_mux
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [1:0]          size,
  input  logic                wr,
  input  logic [31:0]         wdata,
  input  logic [31:0]         rd_lanes,
  output logic [4*ADDR_W-1:0] lane_addr,
  output logic [3:0]          lane_we,
  output logic [31:0]         lane_wdata,
  output logic [31:0]         rdata
);

  always_comb begin
    int unsigned nbytes;
    int unsigned pos;
    nbytes     = size_bytes(size);
    pos        = 0;
    lane_addr  = '0;
    lane_we    = '0;
    lane_wdata = '0;
    rdata      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane_addr[i*ADDR_W +: ADDR_W] = addr + ADDR_W'(i);
      if (i < nbytes) begin
        // Lane 0 carries the most significant byte of the access.
        pos                  = nbytes - 1 - i;
        lane_we[i]           = wr;
        lane_wdata[8*i +: 8] = wdata[8*pos +: 8];
        rdata                = rdata | ({24'b0, rd_lanes[8*i +: 8]} << (8*pos));
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Clocked 256x8 memory responding on the MOV/MOC handshake with a programmable
// number of wait states; byte/halfword/word big-endian accesses with wrap.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  typeData,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        ERR
);

  logic [7:0] mem [0:DEPTH-1];

  state_t state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;

  logic [4*ADDR_W-1:0] lane_addr;
  logic [3:0]          lane_we;
  logic [31:0]         lane_wdata;
  logic [31:0]         rd_lanes;
  logic [31:0]         rdata;

  logic unused_addr_hi;
  assign unused_addr_hi = ^Address[31:ADDR_W];

  mem_lane_mux #(
    .ADDR_W(ADDR_W)
  ) u_lane_mux (
    .addr      (addr_q),
    .size      (size_q),
    .wr        (rw_q == RW_WRITE),
    .wdata     (wdata_q),
    .rd_lanes  (rd_lanes),
    .lane_addr (lane_addr),
    .lane_we   (lane_we),
    .lane_wdata(lane_wdata),
    .rdata     (rdata)
  );

  always_comb begin
    rd_lanes = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rd_lanes[8*i +: 8] = mem[lane_addr[i*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) state <= IDLE;
    else      state <= state_nxt;
  end

  // DONE is only left once MOC has actually been presented to the control unit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MOV) state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (cnt == 4'd1) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    if (MOC && !MOV) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      MOC     <= 1'b0;
      ERR     <= 1'b0;
      DataOut <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MOV) begin
            addr_q  <= Address[ADDR_W-1:0];
            rw_q    <= RW;
            size_q  <= typeData;
            wdata_q <= DataIn;
            cnt     <= 4'(WAIT_STATES);
          end
        end
        WAIT: cnt <= cnt - 4'd1;
        ACCESS: begin
          ERR <= (size_q == SIZE_RSVD);
          if (size_q == SIZE_RSVD)  DataOut <= '0;
          else if (rw_q == RW_READ) DataOut <= rdata;
        end
        DONE: begin
          if (!MOC) begin
            MOC <= 1'b1;
          end else if (!MOV) begin
            MOC <= 1'b0;
            ERR <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // All bytes of a write land on the single ACCESS edge; a reset on that edge wins.
  always_ff @(posedge CLK) begin
    if (CLR && state == ACCESS) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_we[i]) mem[lane_addr[i*ADDR_W +: ADDR_W]] <= lane_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder: two instances (2 and 0 wait
// states) checked against a byte-array reference model.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        clr, mov, rw, moc, err;
  logic [1:0][1:0]   tdata;
  logic [1:0][31:0]  addr, din, dout;

  mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(2)) dut0 (
    .CLK(clk), .CLR(clr[0]), .MOV(mov[0]), .RW(rw[0]), .typeData(tdata[0]),
    .Address(addr[0]), .DataIn(din[0]), .DataOut(dout[0]), .MOC(moc[0]), .ERR(err[0])
  );

  mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(0)) dut1 (
    .CLK(clk), .CLR(clr[1]), .MOV(mov[1]), .RW(rw[1]), .typeData(tdata[1]),
    .Address(addr[1]), .DataIn(din[1]), .DataOut(dout[1]), .MOC(moc[1]), .ERR(err[1])
  );

  int errors = 0;
  int checks = 0;
  logic [7:0]       ref_mem [2][256];
  logic [1:0][31:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [7:0] get_mem(input int d, input int a);
    return (d == 0) ? dut0.mem[a] : dut1.mem[a];
  endfunction

  // Reference: big-endian byte sequence starting at a, addresses wrap mod 256.
  task automatic model_op(input int d, input logic r, input logic [1:0] sz, input int a,
                          input logic [31:0] wd, output logic [31:0] e_d, output logic e_e);
    int n;
    logic [31:0] v;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    e_e = (n == 0);
    if (n == 0) begin
      exp_dout[d] = 32'h0;
    end else if (r) begin
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[d][(a + i) % 256]);
      exp_dout[d] = v;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[d][(a + i) % 256] = 8'(wd >> (8 * (n - 1 - i)));
    end
    e_d = exp_dout[d];
  endtask

  task automatic txn(input int d, input logic r, input logic [1:0] sz, input logic [7:0] a,
                     input logic [31:0] wd, input int hold);
    logic [31:0] e_d, held;
    logic        e_e;
    int          n;
    addr[d]  = {24'($urandom), a};
    rw[d]    = r;
    tdata[d] = sz;
    din[d]   = wd;
    mov[d]   = 1'b1;
    @(posedge clk); #1;
    model_op(d, r, sz, int'(a), wd, e_d, e_e);
    addr[d]  = $urandom;
    din[d]   = $urandom;
    rw[d]    = ~r;
    tdata[d] = 2'($urandom);
    n = 0;
    while (moc[d] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(ws(d) + 2));
    check("dout", dout[d], e_d);
    check("err", {31'b0, err[d]}, {31'b0, e_e});
    held = dout[d];
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_moc", {31'b0, moc[d]}, 32'h1);
      check("hold_dout", dout[d], held);
    end
    mov[d] = 1'b0;
    @(posedge clk); #1;
    check("drop_moc", {31'b0, moc[d]}, 32'h0);
    check("drop_err", {31'b0, err[d]}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  v;
    logic [7:0]  be [4];
    logic [31:0] e_d;
    logic        e_e;
    int          d;
    logic [1:0]  sz;

    clr = '0; mov = '0; rw = '0; tdata = '0; addr = '0; din = '0;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      ref_mem[0][i] = v;
      dut0.mem[i]   = v;
      v = 8'($urandom);
      ref_mem[1][i] = v;
      dut1.mem[i]   = v;
    end
    exp_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_moc", {31'b0, moc[k]}, 32'h0);
      check("rst_err", {31'b0, err[k]}, 32'h0);
      check("rst_dout", dout[k], 32'h0);
    end
    clr = 2'b11;
    @(posedge clk); #1;

    // Byte write then read.
    txn(0, 1'b0, SIZE_BYTE, 8'h10, 32'h0000_00AB, 0);
    txn(0, 1'b1, SIZE_BYTE, 8'h10, 32'h0, 0);
    check("byte_rd", dout[0], 32'h0000_00AB);

    // Word big-endian, then halfword from the middle.
    txn(0, 1'b0, SIZE_WORD, 8'h20, 32'hDEAD_BEEF, 1);
    be = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 4; i++) check("be_mem", {24'b0, get_mem(0, 32 + i)}, {24'b0, be[i]});
    txn(0, 1'b1, SIZE_HALF, 8'h22, 32'h0, 0);
    check("half_rd", dout[0], 32'h0000_BEEF);

    // Wrap-around at the top of memory.
    txn(0, 1'b0, SIZE_WORD, 8'hFF, 32'h1122_3344, 0);
    check("wrap_ff", {24'b0, get_mem(0, 255)}, 32'h11);
    check("wrap_00", {24'b0, get_mem(0, 0)}, 32'h22);
    check("wrap_01", {24'b0, get_mem(0, 1)}, 32'h33);
    check("wrap_02", {24'b0, get_mem(0, 2)}, 32'h44);
    txn(0, 1'b1, SIZE_WORD, 8'hFF, 32'h0, 5);
    check("wrap_rd", dout[0], 32'h1122_3344);

    // Reserved size: error, no memory change, DataOut forced to zero.
    txn(0, 1'b0, SIZE_RSVD, 8'h30, 32'hFFFF_FFFF, 2);
    for (int i = 0; i < 4; i++) check("rsvd_mem", {24'b0, get_mem(0, 48 + i)}, {24'b0, ref_mem[0][48 + i]});

    // Reset during WAIT discards a pending word write.
    addr[0] = 32'h40; rw[0] = 1'b0; tdata[0] = SIZE_WORD; din[0] = 32'hCAFE_F00D; mov[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    @(posedge clk); #1;
    check("rstw_moc", {31'b0, moc[0]}, 32'h0);
    check("rstw_state", 32'(dut0.state), 32'(IDLE));
    clr[0] = 1'b1; mov[0] = 1'b0;
    exp_dout[0] = '0;
    check("rstw_dout", dout[0], 32'h0);
    for (int i = 0; i < 4; i++) check("rstw_mem", {24'b0, get_mem(0, 64 + i)}, {24'b0, ref_mem[0][64 + i]});
    @(posedge clk); #1;

    // Zero wait states: reset before the ACCESS edge discards the write.
    addr[1] = 32'h40; rw[1] = 1'b0; tdata[1] = SIZE_WORD; din[1] = 32'h0BAD_CAFE; mov[1] = 1'b1;
    @(posedge clk); #1;
    clr[1] = 1'b0;
    @(posedge clk); #1;
    check("rst0_moc", {31'b0, moc[1]}, 32'h0);
    clr[1] = 1'b1; mov[1] = 1'b0;
    exp_dout[1] = '0;
    for (int i = 0; i < 4; i++) check("rst0_mem", {24'b0, get_mem(1, 64 + i)}, {24'b0, ref_mem[1][64 + i]});
    @(posedge clk); #1;
    txn(1, 1'b0, SIZE_WORD, 8'h40, 32'h0BAD_CAFE, 0);
    txn(1, 1'b1, SIZE_WORD, 8'h40, 32'h0, 1);
    check("ws0_rd", dout[1], 32'h0BAD_CAFE);

    // Reset while in DONE drops MOC and clears outputs at that edge.
    addr[1] = 32'h41; rw[1] = 1'b1; tdata[1] = SIZE_BYTE; mov[1] = 1'b1;
    @(posedge clk); #1;
    model_op(1, 1'b1, SIZE_BYTE, 8'h41, 32'h0, e_d, e_e);
    repeat (2) @(posedge clk);
    #1;
    check("done_moc", {31'b0, moc[1]}, 32'h1);
    clr[1] = 1'b0;
    @(posedge clk); #1;
    check("rstd_moc", {31'b0, moc[1]}, 32'h0);
    check("rstd_dout", dout[1], 32'h0);
    clr[1] = 1'b1; mov[1] = 1'b0;
    exp_dout[1] = '0;
    @(posedge clk); #1;

    // Randomized traffic on both instances.
    for (int t = 0; t < 60; t++) begin
      d  = int'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? SIZE_RSVD : 2'($urandom_range(0, 2));
      txn(d, 1'($urandom), sz, 8'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++)
        check("final_mem", {24'b0, get_mem(k, i)}, {24'b0, ref_mem[k][i]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
